dice_turn_scheduler: RTL and testbench

// - Turn sequencer for the two-player dice scoring datapath.
// - Sits between the raw throw buttons and the scoring/win logic.
// - Conditions the buttons and enforces the fixed throw order A1, B1, A2, B2.
// - Samples an internal free-running die on each accepted throw and hands the

---
 rtl/dice_turn_scheduler.sv | 151 +++++++++++++++
 tb/tb_dice_turn_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dice_turn_scheduler.sv
// Turn sequencer for the two-player dice datapath: button conditioning, A1/B1/A2/B2 order, die sampling.
// Optional idle auto-throw timer is compiled in with `define DICE_AUTO_THROW_EN.
module dice_turn_scheduler #(
    parameter int DIE_MAX      = 6,
    parameter int DEBOUNCE_CYC = 4,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int TMR_W        = 10
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       throwa,
    input  logic       throwb,
    input  logic       game_over,
    input  logic       new_game,
    output logic       roll_vld,
    output logic [3:0] roll_val,
    output logic       roll_plr,
    output logic [1:0] roll_idx,
    output logic [1:0] turn,
    output logic [3:0] round,
    output logic       roll_auto
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {WAIT_A, WAIT_B, EMIT, HALT} state_t;

    state_t                      state, state_nxt;
    logic   [3:0]                die;
    logic   [1:0]                raw, sync1, sync2, deb, press;
    logic   [1:0][CNT_W-1:0]     cnt;
    logic                        waiting, real_press, timeout, take;

    // Free-running die: 1..DIE_MAX, never 0
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset)                    die <= 4'd1;
        else if (die == 4'(DIE_MAX))   die <= 4'd1;
        else                           die <= die + 4'd1;
    end

    assign raw = {throwb, throwa};

    // Bit 0 = player A, bit 1 = player B. press is high the cycle deb falls.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            press <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    deb[i]   <= sync2[i];
                    cnt[i]   <= '0;
                    press[i] <= ~sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign waiting    = (state == WAIT_A) || (state == WAIT_B);
    assign real_press = ((state == WAIT_A) && press[0]) || ((state == WAIT_B) && press[1]);

`ifdef DICE_AUTO_THROW_EN
    logic [TMR_W-1:0] tmr;
    logic             auto_q;

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset)                                       tmr <= '0;
        else if (new_game || !waiting || state_nxt != state) tmr <= '0;
        else                                              tmr <= tmr + 1'b1;
    end

    assign timeout = waiting && (tmr == TMR_W'(TIMEOUT_CYC - 1));

    // A real press in the same cycle as the timeout wins.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset)    auto_q <= 1'b0;
        else if (take) auto_q <= ~real_press;
    end

    assign roll_auto = roll_vld & auto_q;
`else
    assign timeout   = 1'b0;
    assign roll_auto = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        if (new_game) begin
            state_nxt = WAIT_A;
        end else begin
            case (state)
                WAIT_A, WAIT_B: begin
                    if (game_over) begin
                        state_nxt = HALT;
                    end else if (real_press || timeout) begin
                        take      = 1'b1;
                        state_nxt = EMIT;
                    end
                end
                EMIT:    state_nxt = game_over ? HALT : (roll_idx[0] ? WAIT_A : WAIT_B);
                HALT:    state_nxt = HALT;
                default: state_nxt = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state    <= WAIT_A;
            roll_val <= 4'd1;
            roll_idx <= 2'd0;
            round    <= 4'd0;
        end else begin
            state <= state_nxt;
            if (take) roll_val <= die;
            if (new_game) begin
                roll_idx <= 2'd0;
                round    <= 4'd0;
            end else if (state == EMIT) begin
                roll_idx <= roll_idx + 2'd1;
                if (roll_idx == 2'd3 && round != 4'd15) round <= round + 4'd1;
            end
        end
    end

    // The fixed A,B,A,B order makes the player the low bit of the throw index.
    assign roll_plr = roll_idx[0];
    assign roll_vld = (state == EMIT);

    always_comb begin
        turn = 2'b00;
        case (state)
            WAIT_A:  turn = 2'b01;
            WAIT_B:  turn = 2'b10;
            EMIT:    turn = roll_idx[0] ? 2'b10 : 2'b01;
            default: turn = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_dice_turn_scheduler.sv
// Directed bench for dice_turn_scheduler with DIE_MAX=6, DEBOUNCE_CYC=4, TIMEOUT_CYC=20.
module tb_dice_turn_scheduler;

    logic       clkin, reset, throwa, throwb, game_over, new_game;
    logic       roll_vld, roll_plr, roll_auto;
    logic [3:0] roll_val, round;
    logic [1:0] roll_idx, turn;

    int n_cmp = 0, n_bad = 0;
    int vld_cnt = 0, man_cnt = 0, nrolls;
    logic [3:0] tb_die, last_val, last_exp;
    logic [1:0] last_idx;
    logic       last_plr, last_auto;

    dice_turn_scheduler #(
        .DIE_MAX(6), .DEBOUNCE_CYC(4), .TIMEOUT_CYC(20), .TMR_W(10)
    ) dut (
        .clkin(clkin), .reset(reset), .throwa(throwa), .throwb(throwb),
        .game_over(game_over), .new_game(new_game),
        .roll_vld(roll_vld), .roll_val(roll_val), .roll_plr(roll_plr),
        .roll_idx(roll_idx), .turn(turn), .round(round), .roll_auto(roll_auto)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    // Independent die model; a strobed roll carries the value from the cycle before.
    always @(posedge clkin or negedge reset) begin
        if (!reset)            tb_die <= 4'd1;
        else if (tb_die == 6)  tb_die <= 4'd1;
        else                   tb_die <= tb_die + 4'd1;
    end

    always @(posedge clkin) begin
        #1;
        if (reset && roll_vld) begin
            vld_cnt++;
            if (!roll_auto) man_cnt++;
            last_val  = roll_val;
            last_plr  = roll_plr;
            last_idx  = roll_idx;
            last_auto = roll_auto;
            last_exp  = (tb_die == 4'd1) ? 4'd6 : tb_die - 4'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_press(input logic a, input logic b, input int hold);
        int c0 = man_cnt;
        @(negedge clkin);
        throwa = ~a;
        throwb = ~b;
        repeat (hold) @(negedge clkin);
        throwa = 1'b1;
        throwb = 1'b1;
        repeat (8) @(negedge clkin);
        nrolls = man_cnt - c0;
    endtask

    task automatic pulse_new_game;
        @(negedge clkin);
        new_game = 1'b1;
        @(negedge clkin);
        new_game = 1'b0;
    endtask

    initial begin
        int  c0;
        bit  got;
        reset = 1'b0; throwa = 1'b1; throwb = 1'b1; game_over = 1'b0; new_game = 1'b0;
        repeat (3) @(negedge clkin);
        check("rst_vld",  32'(roll_vld), 0);
        check("rst_val",  32'(roll_val), 1);
        check("rst_plr",  32'(roll_plr), 0);
        check("rst_idx",  32'(roll_idx), 0);
        check("rst_turn", 32'(turn), 32'b01);
        check("rst_round",32'(round), 0);
        check("rst_auto", 32'(roll_auto), 0);
        reset = 1'b1;

        c0 = vld_cnt;
`ifdef DICE_AUTO_THROW_EN
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clkin);
            if (vld_cnt != c0) got = 1'b1;
        end
        check("auto_strobe", 32'(got), 1);
        check("auto_flag",   32'(last_auto), 1);
        check("auto_plr",    32'(last_plr), 0);
`else
        repeat (200) @(negedge clkin);
        check("no_auto_strobe", 32'(vld_cnt - c0), 0);
`endif
        pulse_new_game();

        do_press(1'b1, 1'b0, 10);
        check("a_rolls", 32'(nrolls), 1);
        check("a_plr",   32'(last_plr), 0);
        check("a_idx",   32'(last_idx), 0);
        check("a_val",   32'(last_val), 32'(last_exp));
        check("a_turn",  32'(turn), 32'b10);

        do_press(1'b0, 1'b1, 10);
        check("b_rolls", 32'(nrolls), 1);
        check("b_plr",   32'(last_plr), 1);
        check("b_idx",   32'(last_idx), 1);
        check("b_val",   32'(last_val), 32'(last_exp));
        check("b_turn",  32'(turn), 32'b01);

        c0 = man_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clkin);
            throwa = i[0];
        end
        throwa = 1'b0;
        repeat (50) @(negedge clkin);
        throwa = 1'b1;
        repeat (8) @(negedge clkin);
        check("bounce_rolls", 32'(man_cnt - c0), 1);
        check("bounce_idx",   32'(last_idx), 2);

        pulse_new_game();
        do_press(1'b0, 1'b1, 12);
        check("b_in_wait_a", 32'(nrolls), 0);
        pulse_new_game();
        do_press(1'b1, 1'b1, 10);
        check("ab_rolls", 32'(nrolls), 1);
        check("ab_plr",   32'(last_plr), 0);
        check("ab_idx",   32'(roll_idx), 1);
        check("ab_turn",  32'(turn), 32'b10);

        game_over = 1'b1;
        repeat (2) @(negedge clkin);
        check("halt_turn", 32'(turn), 0);
        do_press(1'b0, 1'b1, 10);
        check("halt_rolls",  32'(nrolls), 0);
        check("halt_turn2",  32'(turn), 0);

        pulse_new_game();
        check("ng_go_turn",  32'(turn), 32'b01);
        check("ng_go_idx",   32'(roll_idx), 0);
        check("ng_go_round", 32'(round), 0);
        @(negedge clkin);
        check("ng_go_rehalt", 32'(turn), 0);
        game_over = 1'b0;
        pulse_new_game();
        check("ng_turn",  32'(turn), 32'b01);
        check("ng_idx",   32'(roll_idx), 0);
        check("ng_round", 32'(round), 0);

        for (int i = 0; i < 8; i++) begin
            do_press(i[0] == 1'b0, i[0] == 1'b1, 10);
            check("seq_rolls", 32'(nrolls), 1);
            check("seq_val",   32'(last_val), 32'(last_exp));
            check("seq_range", 32'(last_val >= 4'd1 && last_val <= 4'd6), 1);
        end
        check("seq_round", 32'(round), 2);
        check("seq_idx",   32'(roll_idx), 0);
        check("seq_turn",  32'(turn), 32'b01);

        for (int i = 0; i < 56; i++) do_press(i[0] == 1'b0, i[0] == 1'b1, 10);
        check("round_sat", 32'(round), 15);
        check("sat_idx",   32'(roll_idx), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
